// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detection, oversampling edge
// counter, LSB-first deserialiser, parity/stop checking and strobes.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic [3:0]            edge_cnt,
    output logic                  dat_samp_en,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state;
    state_t next_state;

    logic                  p16;
    logic                  par_en_lat;
    logic                  par_typ_lat;
    logic                  par_flag;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;

    logic                  legal;
    logic                  start_det;
    logic                  last_edge;
    logic                  par_exp;

    assign legal     = (prescale == 6'd8) || (prescale == 6'd16);
    assign last_edge = (edge_cnt == (p16 ? 4'd15 : 4'd7));
    assign par_exp   = (^shift_reg) ^ par_typ_lat;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; start_det marks the start-bit detection cycle
    always_comb begin
        next_state = state;
        start_det  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!RX_IN && legal) begin
                    next_state = START;
                    start_det  = 1'b1;
                end
            end
            START: begin
                if (last_edge) begin
                    next_state = sampled_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (last_edge && bit_cnt == LAST_BIT) begin
                    next_state = par_en_lat ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (last_edge) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (last_edge) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Frame configuration latched at start detection
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            p16         <= 1'b0;
            par_en_lat  <= 1'b0;
            par_typ_lat <= 1'b0;
        end else if (start_det) begin
            p16         <= (prescale == 6'd16);
            par_en_lat  <= PAR_EN;
            par_typ_lat <= PAR_TYP;
        end
    end

    // Edge counter and sampling enable; detection cycle is edge 0
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_cnt    <= 4'd0;
            dat_samp_en <= 1'b0;
        end else begin
            dat_samp_en <= (next_state != IDLE);
            if (start_det) begin
                edge_cnt <= 4'd1;
            end else if (state != IDLE) begin
                edge_cnt <= last_edge ? 4'd0 : edge_cnt + 4'd1;
            end else begin
                edge_cnt <= 4'd0;
            end
        end
    end

    // Deserialiser and parity check
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_flag  <= 1'b0;
        end else if (start_det) begin
            bit_cnt  <= '0;
            par_flag <= 1'b0;
        end else if (last_edge) begin
            if (state == DATA) begin
                shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
                bit_cnt   <= bit_cnt + 1'b1;
            end else if (state == PARITY) begin
                par_flag <= (sampled_bit != par_exp);
            end
        end
    end

    // Frame-end strobes and output byte
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            if (state == STOP && last_edge) begin
                par_err <= par_flag;
                stp_err <= ~sampled_bit;
                if (sampled_bit && !par_flag) begin
                    data_valid <= 1'b1;
                    P_DATA     <= shift_reg;
                end
            end
        end
    end

endmodule
